id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register placed directly downstream of the register file read ports.
//  - Captures decoded instruction, register file operands, immediate and control bundle.
//  - Detects load-use hazards and inserts one bubble per hazard.
//  - Presents a registered, valid-qualified payload to the EX stage.
//  - Counts bubble and back-pressure cycles for performance debug.
// PARAMETERS
//  XLEN    32  datapath width
//  CTRL_W  16  width of the opaque control bundle (field map lives in riscv_pipe_pkg)
//  CNT_W   16  width of the saturating performance counters
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       synchronous reset, active-low
//  id_valid      in   1       ID holds a valid instruction
//  id_ready      out  1       this stage accepts the ID instruction on this edge
//  id_pc         in   XLEN    instruction PC
//  id_rs1        in   5       rs1 address (same value driven to the register file read_register1)
//  id_rs2        in   5       rs2 address
//  id_rd         in   5       destination register
//  id_uses_rs1   in   1       instruction reads rs1
//  id_uses_rs2   in   1       instruction reads rs2
//  id_rdata1     in   XLEN    register file read_data1 (already write-through forwarded)
//  id_rdata2     in   XLEN    register file read_data2
//  id_imm        in   XLEN    sign-extended immediate
//  id_mem_read   in   1       instruction is a load
//  id_ctrl       in   CTRL_W  remaining control bundle
//  flush         in   1       kill the ID instruction and the EX slot (branch or jump redirect)
//  ex_ready      in   1       EX consumes the slot on this edge
//  ex_valid      out  1       EX slot valid
//  ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_mem_read, ex_ctrl
//                out  =in     registered payload; op1/op2 come from id_rdata1/id_rdata2
//  hazard_stall  out  1       combinational load-use stall indication to IF/ID
//  bubble_cnt    out  CNT_W   count of bubbles inserted, saturating
//  stall_cnt     out  CNT_W   count of cycles with ex_valid && !ex_ready, saturating
// BEHAVIOUR
//  - Reset (!reset_n at an edge): ex_valid=0; all ex_* payload = 0; both counters = 0.
//    Reset applies mid-operation as well; the in-flight instruction is lost.
//  - adv = !ex_valid || ex_ready.
//  - hazard = id_valid && ex_valid && ex_mem_read && ex_rd!=0 &&
//      ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
//  - hazard_stall = hazard && !flush.
//  - id_ready = flush || (adv && !hazard).
//  - Edge priority, highest first:
//    1. reset.
//    2. flush: ex_valid<=0, payload zeroed. The ID instruction is consumed and discarded.
//    3. adv && id_valid && !hazard: load payload, ex_valid<=1. Latency ID->EX is 1 cycle.
//    4. adv otherwise: ex_valid<=0, payload zeroed (bubble). bubble_cnt++ if hazard.
//    5. !adv: hold everything.
//  - Back-to-back hazard: only one bubble. Next cycle the load has left EX, so hazard=0.
//  - Hazard with ex_ready=0: no bubble yet; hold, and bubble on the edge where ex_ready=1.
//  - rd=x0 never causes a hazard.
//  - Counters saturate at all-ones and never wrap.
//  - stall_cnt increments every edge where ex_valid && !ex_ready, flush included.
// CONFIGURATION
//  ID_EX_FWD_MEM_EN defined:
//    - Adds inputs mem_fwd_valid(1), mem_fwd_rd(5), mem_fwd_data(XLEN).
//    - At capture, ex_op1 <= mem_fwd_data if mem_fwd_valid && mem_fwd_rd!=0 && mem_fwd_rd==id_rs1;
//      otherwise ex_op1 <= id_rdata1. Same rule for ex_op2 with id_rs2.
//  Not defined: ports absent; operands are captured straight from id_rdata1/id_rdata2.
// STRUCTURE
//  - riscv_pipe_pkg: XLEN, REG_ADDR_W=5, CTRL_W, control-bundle field localparams,
//    typedef of the ID/EX payload struct.
//  - Sub-module id_ex_hazard_detect: pure combinational compare producing hazard.
//    Instanced once; payload register, flow control and counters stay in id_ex_stage.
// TESTING
//  1. reset_n=0 for 2 cycles, then 1 -> ex_valid=0, ex_op1=0, bubble_cnt=0, id_ready=1.
//  2. ADD x3,x1,x2 with rdata1=5, rdata2=7, ex_ready=1 -> next cycle ex_valid=1, ex_op1=5,
//     ex_op2=7, ex_rd=3.
//  3. LW x5 in EX, then ADD uses rs1=x5 in ID -> hazard_stall=1, id_ready=0, one bubble,
//     bubble_cnt=1; ADD enters EX one cycle later.
//  4. LW x0 in EX, then ID reads x0 -> no stall; LW x5 in EX with ex_ready=0 for 3 cycles
//     -> hold, stall_cnt=3, then one bubble.
//  5. flush during hazard -> ex_valid=0 next cycle, id_ready=1, bubble_cnt unchanged.
//  6. ID_EX_FWD_MEM_EN: mem_fwd rd=4 data=0xDEAD, id_rs2=4 rdata2=0 -> ex_op2=0xDEAD;
//     with mem_fwd_rd=0 -> ex_op2=0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: datapath widths, control-bundle field map and the ID/EX payload.
// The optional MEM-stage operand forward (ID_EX_FWD_MEM_EN) uses fwd_hit() below.
package riscv_pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 16;

   // Control bundle field map; the ID/EX register carries it through untouched.
   localparam int CTRL_ALU_OP_LSB    = 0;
   localparam int CTRL_ALU_OP_W      = 4;
   localparam int CTRL_ALU_SRC_BIT   = 4;
   localparam int CTRL_MEM_WRITE_BIT = 5;
   localparam int CTRL_REG_WRITE_BIT = 6;
   localparam int CTRL_BRANCH_BIT    = 7;
   localparam int CTRL_JUMP_BIT      = 8;
   localparam int CTRL_MEM_SIZE_LSB  = 9;
   localparam int CTRL_MEM_SIZE_W    = 3;
   localparam int CTRL_MEM_UNS_BIT   = 12;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xword_t;

   typedef struct packed {
      xword_t              pc;
      reg_addr_t           rs1;
      reg_addr_t           rs2;
      reg_addr_t           rd;
      xword_t              op1;
      xword_t              op2;
      xword_t              imm;
      logic                mem_read;
      logic [CTRL_W-1:0]   ctrl;
   } id_ex_payload_t;

   // x0 is hard-wired zero, so a forward targeting it is never a real hit.
   function automatic logic fwd_hit(input logic valid, input reg_addr_t fwd_rd,
                                    input reg_addr_t rs);
      return valid && (fwd_rd != '0) && (fwd_rd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX -> EX signal bundle. The stage uses the slave view; the driving
// environment (ID producer plus EX consumer) uses the master view.
interface id_ex_stage_if;
   import riscv_pipe_pkg::*;

   // Handshake: id side transfers on an edge where id_valid && id_ready; the EX slot
   // is consumed on an edge where ex_valid && ex_ready. A valid slot and its payload
   // hold steady until consumed (or flushed); ex_ready may depend on nothing here.
   logic              id_valid;
   logic              id_ready;
   xword_t            id_pc;
   reg_addr_t         id_rs1;
   reg_addr_t         id_rs2;
   reg_addr_t         id_rd;
   logic              id_uses_rs1;
   logic              id_uses_rs2;
   xword_t            id_rdata1;
   xword_t            id_rdata2;
   xword_t            id_imm;
   logic              id_mem_read;
   logic [CTRL_W-1:0] id_ctrl;

   logic              ex_ready;
   logic              ex_valid;
   xword_t            ex_pc;
   reg_addr_t         ex_rs1;
   reg_addr_t         ex_rs2;
   reg_addr_t         ex_rd;
   xword_t            ex_op1;
   xword_t            ex_op2;
   xword_t            ex_imm;
   logic              ex_mem_read;
   logic [CTRL_W-1:0] ex_ctrl;

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rdata1, id_rdata2, id_imm, id_mem_read, id_ctrl, ex_ready,
      output id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2,
             ex_imm, ex_mem_read, ex_ctrl
   );

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_rdata1, id_rdata2, id_imm, id_mem_read, id_ctrl, ex_ready,
      input  id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2,
             ex_imm, ex_mem_read, ex_ctrl
   );

endinterface

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard compare: ID source registers against a load sitting in EX.
module id_ex_hazard_detect
   import riscv_pipe_pkg::*;
(
   input  logic      id_valid,
   input  reg_addr_t id_rs1,
   input  reg_addr_t id_rs2,
   input  logic      id_uses_rs1,
   input  logic      id_uses_rs2,
   input  logic      ex_valid,
   input  logic      ex_mem_read,
   input  reg_addr_t ex_rd,
   output logic      hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

   // A load to x0 writes nothing, so it can never create a dependency.
   assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating perf counters.
// Define ID_EX_FWD_MEM_EN to add the MEM-stage operand forward at capture.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   id_ex_stage_if.slave     bus,
   input  logic             flush,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt
`ifdef ID_EX_FWD_MEM_EN
   ,
   input  logic             mem_fwd_valid,
   input  reg_addr_t        mem_fwd_rd,
   input  xword_t           mem_fwd_data
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   id_ex_payload_t ex_q;
   id_ex_payload_t cap;
   logic           ex_valid_q;
   logic           adv;
   logic           hazard;

   assign adv = !ex_valid_q || bus.ex_ready;

   id_ex_hazard_detect u_hazard (
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .id_uses_rs1 (bus.id_uses_rs1),
      .id_uses_rs2 (bus.id_uses_rs2),
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_q.mem_read),
      .ex_rd       (ex_q.rd),
      .hazard      (hazard)
   );

   // A flush consumes the ID instruction regardless of any hazard.
   assign hazard_stall = hazard && !flush;
   assign bus.id_ready = flush || (adv && !hazard);

   always_comb begin
      cap          = '0;
      cap.pc       = bus.id_pc;
      cap.rs1      = bus.id_rs1;
      cap.rs2      = bus.id_rs2;
      cap.rd       = bus.id_rd;
      cap.op1      = bus.id_rdata1;
      cap.op2      = bus.id_rdata2;
      cap.imm      = bus.id_imm;
      cap.mem_read = bus.id_mem_read;
      cap.ctrl     = bus.id_ctrl;
`ifdef ID_EX_FWD_MEM_EN
      if (fwd_hit(mem_fwd_valid, mem_fwd_rd, bus.id_rs1)) cap.op1 = mem_fwd_data;
      if (fwd_hit(mem_fwd_valid, mem_fwd_rd, bus.id_rs2)) cap.op2 = mem_fwd_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (flush) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (adv) begin
         if (bus.id_valid && !hazard) begin
            ex_valid_q <= 1'b1;
            ex_q       <= cap;
         end else begin
            // Empty slot: either nothing offered or a load-use bubble.
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (!flush && adv && hazard && (bubble_cnt != CNT_MAX))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         if (ex_valid_q && !bus.ex_ready && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_pc       = ex_q.pc;
   assign bus.ex_rs1      = ex_q.rs1;
   assign bus.ex_rs2      = ex_q.rs2;
   assign bus.ex_rd       = ex_q.rd;
   assign bus.ex_op1      = ex_q.op1;
   assign bus.ex_op2      = ex_q.op2;
   assign bus.ex_imm      = ex_q.imm;
   assign bus.ex_mem_read = ex_q.mem_read;
   assign bus.ex_ctrl     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, counter saturation and reset sequences,
// then randomized traffic against a slot-level reference model.
`timescale 1ns/1ps
module tb_id_ex_stage;
   import riscv_pipe_pkg::*;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             flush = 1'b0;
   logic             hazard_stall;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] stall_cnt;
`ifdef ID_EX_FWD_MEM_EN
   logic             mem_fwd_valid = 1'b0;
   logic [4:0]       mem_fwd_rd = 5'd0;
   logic [31:0]      mem_fwd_data = 32'd0;
`endif

   id_ex_stage_if bus();

   id_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .flush        (flush),
      .hazard_stall (hazard_stall),
      .bubble_cnt   (bubble_cnt),
      .stall_cnt    (stall_cnt)
`ifdef ID_EX_FWD_MEM_EN
      ,
      .mem_fwd_valid(mem_fwd_valid),
      .mem_fwd_rd   (mem_fwd_rd),
      .mem_fwd_data (mem_fwd_data)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents of the EX slot plus the two counters.
   typedef struct {
      bit          valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] op1, op2, imm;
      bit          mem_read;
      logic [15:0] ctrl;
   } slot_t;

   slot_t m;
   int    m_bubble;
   int    m_stall;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 0; s.pc = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
      s.op1 = 0; s.op2 = 0; s.imm = 0; s.mem_read = 0; s.ctrl = 0;
      return s;
   endfunction

`ifdef ID_EX_FWD_MEM_EN
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rdata);
      if (mem_fwd_valid && mem_fwd_rd != 5'd0 && mem_fwd_rd == rs) return mem_fwd_data;
      return rdata;
   endfunction
`else
   function automatic logic [31:0] operand(input logic [31:0] rdata);
      return rdata;
   endfunction
`endif

   function automatic slot_t captured();
      slot_t s;
      s.valid = 1; s.pc = bus.id_pc; s.rs1 = bus.id_rs1; s.rs2 = bus.id_rs2; s.rd = bus.id_rd;
`ifdef ID_EX_FWD_MEM_EN
      s.op1 = operand(bus.id_rs1, bus.id_rdata1);
      s.op2 = operand(bus.id_rs2, bus.id_rdata2);
`else
      s.op1 = operand(bus.id_rdata1);
      s.op2 = operand(bus.id_rdata2);
`endif
      s.imm = bus.id_imm; s.mem_read = bus.id_mem_read; s.ctrl = bus.id_ctrl;
      return s;
   endfunction

   function automatic bit model_hazard();
      bit dep;
      dep = (bus.id_uses_rs1 && bus.id_rs1 == m.rd) || (bus.id_uses_rs2 && bus.id_rs2 == m.rd);
      return bus.id_valid && m.valid && m.mem_read && (m.rd != 5'd0) && dep;
   endfunction

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".ex_valid"},    bus.ex_valid,    m.valid);
      check({tag, ".ex_pc"},       bus.ex_pc,       m.pc);
      check({tag, ".ex_rs1"},      bus.ex_rs1,      m.rs1);
      check({tag, ".ex_rs2"},      bus.ex_rs2,      m.rs2);
      check({tag, ".ex_rd"},       bus.ex_rd,       m.rd);
      check({tag, ".ex_op1"},      bus.ex_op1,      m.op1);
      check({tag, ".ex_op2"},      bus.ex_op2,      m.op2);
      check({tag, ".ex_imm"},      bus.ex_imm,      m.imm);
      check({tag, ".ex_mem_read"}, bus.ex_mem_read, m.mem_read);
      check({tag, ".ex_ctrl"},     bus.ex_ctrl,     m.ctrl);
      check({tag, ".bubble_cnt"},  bubble_cnt,      m_bubble);
      check({tag, ".stall_cnt"},   stall_cnt,       m_stall);
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic step(input string tag);
      bit hz, adv;
      #1;
      hz  = model_hazard();
      adv = !m.valid || bus.ex_ready;
      check({tag, ".hazard_stall"}, hazard_stall, hz && !flush);
      check({tag, ".id_ready"},     bus.id_ready, flush || (adv && !hz));
      @(posedge clk);
      if (m.valid && !bus.ex_ready) m_stall = sat(m_stall + 1);
      if (flush) m = empty_slot();
      else if (adv) begin
         if (bus.id_valid && !hz) m = captured();
         else begin
            if (hz) m_bubble = sat(m_bubble + 1);
            m = empty_slot();
         end
      end
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      repeat (n) @(posedge clk);
      m = empty_slot(); m_bubble = 0; m_stall = 0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drive_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input bit u1, input bit u2,
                           input logic [31:0] r1, input logic [31:0] r2, input bit mr);
      bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
      bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
      bus.id_rdata1 = r1; bus.id_rdata2 = r2; bus.id_mem_read = mr;
      bus.id_pc = $urandom; bus.id_imm = $urandom; bus.id_ctrl = 16'($urandom);
   endtask

   typedef struct {
      bit v; logic [4:0] rs1, rs2, rd; bit u1, u2; logic [31:0] r1, r2; bit mr, fl, er;
      bit x_hs, x_ir, x_ev; logic [31:0] x_op1, x_op2; logic [4:0] x_rd; int x_bc, x_sc;
   } vec_t;

   vec_t vt[15];

   initial begin
      // Directed sequence: ADD, load-use bubble, x0 load, held hazard, flush during hazard.
      //          v rs1 rs2 rd u1 u2 r1   r2 mr fl er | hs ir ev op1 op2 rd bc sc
      vt[0]  = '{1, 1, 2, 3, 1, 1, 5,   7,  0, 0, 1,   0, 1, 1, 5,   7,  3, 0, 0};
      vt[1]  = '{1, 1, 0, 5, 1, 0, 100, 0,  1, 0, 1,   0, 1, 1, 100, 0,  5, 0, 0};
      vt[2]  = '{1, 5, 2, 6, 1, 1, 11,  22, 0, 0, 1,   1, 0, 0, 0,   0,  0, 1, 0};
      vt[3]  = '{1, 5, 2, 6, 1, 1, 11,  22, 0, 0, 1,   0, 1, 1, 11,  22, 6, 1, 0};
      vt[4]  = '{1, 1, 0, 0, 1, 0, 8,   0,  1, 0, 1,   0, 1, 1, 8,   0,  0, 1, 0};
      vt[5]  = '{1, 0, 0, 7, 1, 1, 0,   0,  0, 0, 1,   0, 1, 1, 0,   0,  7, 1, 0};
      vt[6]  = '{1, 2, 0, 5, 1, 0, 40,  0,  1, 0, 1,   0, 1, 1, 40,  0,  5, 1, 0};
      vt[7]  = '{1, 5, 3, 8, 1, 1, 9,   3,  0, 0, 0,   1, 0, 1, 40,  0,  5, 1, 1};
      vt[8]  = '{1, 5, 3, 8, 1, 1, 9,   3,  0, 0, 0,   1, 0, 1, 40,  0,  5, 1, 2};
      vt[9]  = '{1, 5, 3, 8, 1, 1, 9,   3,  0, 0, 0,   1, 0, 1, 40,  0,  5, 1, 3};
      vt[10] = '{1, 5, 3, 8, 1, 1, 9,   3,  0, 0, 1,   1, 0, 0, 0,   0,  0, 2, 3};
      vt[11] = '{1, 5, 3, 8, 1, 1, 9,   3,  0, 0, 1,   0, 1, 1, 9,   3,  8, 2, 3};
      vt[12] = '{1, 1, 0, 9, 1, 0, 1,   0,  1, 0, 1,   0, 1, 1, 1,   0,  9, 2, 3};
      vt[13] = '{1, 0, 9, 10,0, 1, 0,   0,  0, 1, 0,   0, 1, 0, 0,   0,  0, 2, 4};
      vt[14] = '{0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 1,   0, 1, 0, 0,   0,  0, 2, 4};

      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.ex_ready = 1'b1;
      m = empty_slot(); m_bubble = 0; m_stall = 0;

      // Reset values
      do_reset(2);
      #1;
      check("reset.ex_valid",   bus.ex_valid, 1'b0);
      check("reset.ex_op1",     bus.ex_op1,   32'd0);
      check("reset.bubble_cnt", bubble_cnt,   4'd0);
      check("reset.stall_cnt",  stall_cnt,    4'd0);
      check("reset.id_ready",   bus.id_ready, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive_id(vt[i].v, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].u1, vt[i].u2,
                  vt[i].r1, vt[i].r2, vt[i].mr);
         flush = vt[i].fl; bus.ex_ready = vt[i].er;
         #1;
         check({tag, ".tbl_hazard_stall"}, hazard_stall, vt[i].x_hs);
         check({tag, ".tbl_id_ready"},     bus.id_ready, vt[i].x_ir);
         step(tag);
         check({tag, ".tbl_ex_valid"},   bus.ex_valid, vt[i].x_ev);
         check({tag, ".tbl_ex_op1"},     bus.ex_op1,   vt[i].x_op1);
         check({tag, ".tbl_ex_op2"},     bus.ex_op2,   vt[i].x_op2);
         check({tag, ".tbl_ex_rd"},      bus.ex_rd,    vt[i].x_rd);
         check({tag, ".tbl_bubble_cnt"}, bubble_cnt,   vt[i].x_bc);
         check({tag, ".tbl_stall_cnt"},  stall_cnt,    vt[i].x_sc);
      end
      flush = 1'b0;

      // stall_cnt saturates at all-ones
      do_reset(1);
      drive_id(1, 1, 2, 3, 1, 1, 1, 2, 0); bus.ex_ready = 1'b1;
      step("satS.load");
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.ex_ready = 1'b0;
      repeat (20) step("satS.hold");
      check("satS.stall_cnt_sat", stall_cnt, 4'hF);
      bus.ex_ready = 1'b1;
      step("satS.drain");

      // bubble_cnt saturates at all-ones
      for (int i = 0; i < 18; i++) begin
         drive_id(1, 1, 0, 5, 1, 0, 3, 0, 1);
         step("satB.lw");
         drive_id(1, 2, 5, 6, 0, 1, 4, 5, 0);
         step("satB.use");
      end
      check("satB.bubble_cnt_sat", bubble_cnt, 4'hF);

      // Reset mid-operation drops the in-flight instruction
      drive_id(1, 1, 2, 3, 1, 1, 32'h55, 32'h66, 0);
      step("midrst.load");
      do_reset(1);
      #1;
      check("midrst.ex_valid",   bus.ex_valid, 1'b0);
      check("midrst.ex_op1",     bus.ex_op1,   32'd0);
      check("midrst.bubble_cnt", bubble_cnt,   4'd0);
      check("midrst.stall_cnt",  stall_cnt,    4'd0);
      @(posedge clk); #1;

`ifdef ID_EX_FWD_MEM_EN
      mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'hDEAD;
      drive_id(1, 1, 4, 2, 1, 1, 32'd3, 32'd0, 0); bus.ex_ready = 1'b1;
      step("fwd.hit");
      check("fwd.hit_op2", bus.ex_op2, 32'hDEAD);
      check("fwd.hit_op1", bus.ex_op1, 32'd3);
      mem_fwd_rd = 5'd0;
      drive_id(1, 0, 0, 2, 1, 1, 32'd0, 32'd0, 0);
      step("fwd.x0");
      check("fwd.x0_op2", bus.ex_op2, 32'd0);
      mem_fwd_valid = 1'b0;
`endif

      // Randomized traffic against the model; small register range provokes hazards.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
            compare_all("rnd.reset");
         end else begin
            drive_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
                     ($urandom_range(0, 2) == 0));
            flush = ($urandom_range(0, 9) == 0);
            bus.ex_ready = ($urandom_range(0, 9) < 7);
`ifdef ID_EX_FWD_MEM_EN
            mem_fwd_valid = $urandom_range(0, 1);
            mem_fwd_rd = 5'($urandom_range(0, 3));
            mem_fwd_data = $urandom;
`endif
            step($sformatf("rnd%0d", i));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
